// File: rtl/mc_sequencer_if.sv
// Handshake/bus bundle between mc_sequencer, mem_ctrl and the compute datapath.
// master = sequencer side, slave = mem_ctrl + datapath side.
interface mc_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [2:0]            mc_data_contition;
    logic                  mc_data_length;
    logic [DATA_WIDTH-1:0] mc_data_in;
    logic [DATA_WIDTH-1:0] mc_data_out_opa;
    logic [DATA_WIDTH-1:0] mc_data_out_opb;
    logic                  mc_done;
    logic                  mc_data_done;
    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;

    modport master (
        output mc_data_contition, mc_data_length, mc_data_in, mc_data_done,
        output op_valid, op_a, op_b, res_ready,
        input  mc_data_out_opa, mc_data_out_opb, mc_done, op_ready, res_valid, res_data
    );

    modport slave (
        input  mc_data_contition, mc_data_length, mc_data_in, mc_data_done,
        input  op_valid, op_a, op_b, res_ready,
        output mc_data_out_opa, mc_data_out_opb, mc_done, op_ready, res_valid, res_data
    );
endinterface

// File: rtl/mc_sequencer.sv
// Requester-side sequencer: read operand pair, hand it downstream, write the result back, repeat.
// Optional SQ_TIMEOUT_EN adds a per-request watchdog (TIMEOUT_CYCLES) driving the sticky err flag.
module mc_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
`ifdef SQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                 sq_clk,
    input  logic                 sq_reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] job_count,
    output logic                 busy,
    output logic                 job_done,
    output logic                 err,
    mc_sequencer_if.master       bus
);

    localparam logic [2:0] COND_IDLE  = 3'b000;
    localparam logic [2:0] COND_READ  = 3'b011;
    localparam logic [2:0] COND_WRITE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_RD, S_DELIVER, S_WAIT_RES, S_REQ_WR, S_DONE
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [2:0]            r_cond,      w_cond_nxt;
    logic                  r_len,       w_len_nxt;
    logic [DATA_WIDTH-1:0] r_data_in,   w_data_in_nxt;
    logic [DATA_WIDTH-1:0] r_op_a,      w_op_a_nxt;
    logic [DATA_WIDTH-1:0] r_op_b,      w_op_b_nxt;
    logic                  r_op_valid,  w_op_valid_nxt;
    logic                  r_data_done, w_data_done_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic                  r_job_done,  w_job_done_nxt;
    logic                  r_err,       w_err_nxt;
    logic [CNT_WIDTH-1:0]  r_remaining, w_remaining_nxt;
    logic                  w_rd_done;
    logic                  w_wr_done;

    // A read completion only counts once READ_PAIR is actually on the bus; after a write
    // the first REQ_RD cycle still shows IDLE so the new read starts after mc_data_done.
    assign w_rd_done = (r_state == S_REQ_RD) && (r_cond == COND_READ) && bus.mc_done;
    assign w_wr_done = (r_state == S_REQ_WR) && bus.mc_done;

`ifdef SQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cond_nxt      = r_cond;
        w_len_nxt       = r_len;
        w_data_in_nxt   = r_data_in;
        w_op_a_nxt      = r_op_a;
        w_op_b_nxt      = r_op_b;
        w_op_valid_nxt  = r_op_valid;
        w_busy_nxt      = r_busy;
        w_err_nxt       = r_err;
        w_remaining_nxt = r_remaining;
        w_data_done_nxt = 1'b0;
        w_job_done_nxt  = 1'b0;
`ifdef SQ_TIMEOUT_EN
        w_wait_nxt      = '0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_err_nxt = 1'b0;
                    if (job_count != '0) begin
                        w_remaining_nxt = job_count;
                        w_busy_nxt      = 1'b1;
                        w_cond_nxt      = COND_READ;
                        w_len_nxt       = 1'b1;
                        w_state_nxt     = S_REQ_RD;
                    end else begin
                        w_job_done_nxt  = 1'b1;
                    end
                end
            end
            S_REQ_RD: begin
                if (w_rd_done) begin
                    w_op_a_nxt     = bus.mc_data_out_opa;
                    w_op_b_nxt     = bus.mc_data_out_opb;
                    w_cond_nxt     = COND_IDLE;
                    w_op_valid_nxt = 1'b1;
                    w_state_nxt    = S_DELIVER;
                end else begin
                    w_cond_nxt     = COND_READ;
                    w_len_nxt      = 1'b1;
                end
            end
            S_DELIVER: begin
                if (r_op_valid && bus.op_ready) begin
                    w_op_valid_nxt = 1'b0;
                    w_state_nxt    = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (bus.res_valid) begin
                    w_data_in_nxt = bus.res_data;
                    w_cond_nxt    = COND_WRITE;
                    w_len_nxt     = 1'b0;
                    w_state_nxt   = S_REQ_WR;
                end
            end
            S_REQ_WR: begin
                if (w_wr_done) begin
                    w_cond_nxt      = COND_IDLE;
                    w_data_done_nxt = 1'b1;
                    w_remaining_nxt = r_remaining - CNT_WIDTH'(1);
                    w_state_nxt     = (r_remaining == CNT_WIDTH'(1)) ? S_DONE : S_REQ_RD;
                end
            end
            S_DONE: begin
                w_job_done_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef SQ_TIMEOUT_EN
        // Watchdog: abandons a stalled request and returns to IDLE without any completion pulse.
        if (((r_state == S_REQ_RD) && !w_rd_done) || ((r_state == S_REQ_WR) && !w_wr_done)) begin
            if (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                w_cond_nxt      = COND_IDLE;
                w_len_nxt       = 1'b0;
                w_err_nxt       = 1'b1;
                w_busy_nxt      = 1'b0;
                w_remaining_nxt = '0;
                w_state_nxt     = S_IDLE;
            end else begin
                w_wait_nxt      = r_wait + WAIT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge sq_clk or negedge sq_reset) begin
        if (!sq_reset) begin
            r_state     <= S_IDLE;
            r_cond      <= COND_IDLE;
            r_len       <= 1'b0;
            r_data_in   <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_valid  <= 1'b0;
            r_data_done <= 1'b0;
            r_busy      <= 1'b0;
            r_job_done  <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cond      <= w_cond_nxt;
            r_len       <= w_len_nxt;
            r_data_in   <= w_data_in_nxt;
            r_op_a      <= w_op_a_nxt;
            r_op_b      <= w_op_b_nxt;
            r_op_valid  <= w_op_valid_nxt;
            r_data_done <= w_data_done_nxt;
            r_busy      <= w_busy_nxt;
            r_job_done  <= w_job_done_nxt;
            r_err       <= w_err_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

`ifdef SQ_TIMEOUT_EN
    always_ff @(posedge sq_clk or negedge sq_reset) begin
        if (!sq_reset) begin
            r_wait <= '0;
        end else begin
            r_wait <= w_wait_nxt;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy                  = r_busy;
    assign job_done              = r_job_done;
    assign bus.mc_data_contition = r_cond;
    assign bus.mc_data_length    = r_len;
    assign bus.mc_data_in        = r_data_in;
    assign bus.mc_data_done      = r_data_done;
    assign bus.op_valid          = r_op_valid;
    assign bus.op_a              = r_op_a;
    assign bus.op_b              = r_op_b;
    assign bus.res_ready         = (r_state == S_WAIT_RES);

endmodule
